// File: rtl/tug_match_ctrl_if.sv
// +----------------------------------------------------------------------+
// | tug_match_ctrl_if : press/end-light inputs and playfield/score outputs
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface tug_match_ctrl_if;
  logic       L_press;
  logic       R_press;
  logic       left_end;
  logic       right_end;
  logic       L_move;
  logic       R_move;
  logic       round_reset;
  logic [2:0] score_L;
  logic [2:0] score_R;
  logic       winner;
  logic       match_over;

  // master drives presses and end lights; slave is the match controller
  modport master (
    output L_press, R_press, left_end, right_end,
    input  L_move, R_move, round_reset, score_L, score_R, winner, match_over
  );

  modport slave (
    input  L_press, R_press, left_end, right_end,
    output L_move, R_move, round_reset, score_L, score_R, winner, match_over
  );
endinterface

`default_nettype wire

// File: rtl/tug_match_ctrl.sv
// +----------------------------------------------------------------------+
// | tug_match_ctrl : tug-of-war round/match sequencer and score keeper   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tug_match_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int WIN_SCORE   = 3
) (
  input wire logic        Clock,
  input wire logic        Reset,
  tug_match_ctrl_if.slave bus
);

  localparam int          c_CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]  c_WIN_SCORE = 3'(WIN_SCORE);

  typedef enum logic [1:0] {
    START = 2'd0,
    PLAY  = 2'd1,
    HOLD  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [c_CNT_W-1:0] r_hold_cnt;
  logic [2:0]         r_score_L;
  logic [2:0]         r_score_R;
  logic               r_winner;
  logic               w_win_L;
  logic               w_win_R;
  logic               w_hold_last;
  logic               w_L_move;
  logic               w_R_move;
  logic               w_round_reset;
  logic               w_match_over;

  assign w_hold_last = (r_hold_cnt == c_HOLD_LAST);

  always_comb begin
    w_next_state  = r_state;
    w_win_L       = 1'b0;
    w_win_R       = 1'b0;
    w_L_move      = 1'b0;
    w_R_move      = 1'b0;
    w_round_reset = 1'b0;
    w_match_over  = 1'b0;
    // Reset overrides the decode so the playfield is held centred immediately
    if (Reset) begin
      w_round_reset = 1'b1;
      w_next_state  = START;
    end else begin
      unique case (r_state)
        START: begin
          w_round_reset = 1'b1;
          w_next_state  = PLAY;
        end
        PLAY: begin
          if (bus.L_press && bus.R_press) begin
            w_next_state = PLAY;
          end else if (bus.L_press && bus.left_end) begin
            w_win_L      = 1'b1;
            w_next_state = HOLD;
          end else if (bus.R_press && bus.right_end) begin
            w_win_R      = 1'b1;
            w_next_state = HOLD;
          end else begin
            w_L_move = bus.L_press;
            w_R_move = bus.R_press;
          end
        end
        HOLD: begin
          if (w_hold_last) begin
            w_next_state = ((r_score_L == c_WIN_SCORE) || (r_score_R == c_WIN_SCORE))
                         ? OVER : START;
          end
        end
        OVER: begin
          w_match_over = 1'b1;
        end
        default: w_next_state = START;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= START;
      r_hold_cnt <= '0;
      r_score_L  <= 3'd0;
      r_score_R  <= 3'd0;
      r_winner   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == HOLD) && !w_hold_last) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
      if (w_win_L) begin
        r_score_L <= r_score_L + 3'd1;
        r_winner  <= 1'b0;
      end
      if (w_win_R) begin
        r_score_R <= r_score_R + 3'd1;
        r_winner  <= 1'b1;
      end
    end
  end

  assign bus.L_move      = w_L_move;
  assign bus.R_move      = w_R_move;
  assign bus.round_reset = w_round_reset;
  assign bus.match_over  = w_match_over;
  assign bus.score_L     = r_score_L;
  assign bus.score_R     = r_score_R;
  assign bus.winner      = r_winner;

endmodule

`default_nettype wire

// File: doc/tug_match_ctrl.md
# tug_match_ctrl

Match sequencer for the tug-of-war game. Sits between the two button edge detectors and the nine-light playfield. It gates player move pulses into the light array and detects round wins at either end. It also holds the win for a fixed display time, keeps per-player round scores, issues round resets to the playfield, and stops play once a player reaches the match score.

## Interface
Parameters:
- HOLD_CYCLES, default 4, cycles the round result is held before the next round; must be ≥ 1
- WIN_SCORE, default 3, rounds needed to win the match; must be 1..7

Ports:
- Clock  in  1  system clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-high; restarts the whole match
- L_press  in  1  one-cycle pulse, left player pressed
- R_press  in  1  one-cycle pulse, right player pressed
- left_end  in  1  leftmost playfield light is on
- right_end  in  1  rightmost playfield light is on
- L_move  out  1  qualified left pulse to the light array
- R_move  out  1  qualified right pulse to the light array
- round_reset  out  1  drives the light array Reset (re-centres the light)
- score_L  out  3  left rounds won
- score_R  out  3  right rounds won
- winner  out  1  winner of the most recent round: 0 = left, 1 = right
- match_over  out  1  match finished; play is frozen

## Operation
- States: START, PLAY, HOLD, OVER. Encoding is free.
- START:
  - round_reset = 1, moves blocked.
  - Next state is PLAY unconditionally.
- PLAY, arbitration:
  - Both L_press and R_press in the same cycle: the presses cancel. L_move = R_move = 0, no win check, stay in PLAY.
  - Only L_press with left_end = 1: left round win. L_move = 0, score_L += 1, winner <= 0, go to HOLD.
  - Only R_press with right_end = 1: right round win. R_move = 0, score_R += 1, winner <= 1, go to HOLD.
  - Otherwise: L_move = L_press & ~R_press and R_move = R_press & ~L_press, combinational with zero latency. Stay in PLAY.
- HOLD:
  - Moves are blocked and round_reset = 0, so the playfield freezes on the end light.
  - A hold counter runs from 0 to HOLD_CYCLES-1.
  - On the last count: if score_L or score_R equals WIN_SCORE, go to OVER; else go to START. The counter clears on exit.
- OVER:
  - match_over = 1, moves blocked, round_reset = 0.
  - Scores and winner are frozen.
  - The only exit is Reset.
- Scores never exceed WIN_SCORE, because the match ends first. No wrap-around is possible. Score width is fixed at 3 bits.
- round_reset, match_over, L_move and R_move are decoded from state, plus the inputs in PLAY. They are glitch-free with respect to registered state.

## Timing
- While Reset = 1:
  - State is forced to START, so round_reset = 1 throughout.
  - score_L = score_R = 0, winner = 0, match_over = 0, L_move = R_move = 0, hold counter = 0.
- First cycle after Reset falls: state is START and round_reset = 1 for exactly one cycle. PLAY starts on the next cycle.
- Reset asserted in any state, including mid-HOLD or OVER, takes effect on the next edge and behaves as above.
- Winning press in PLAY at cycle n:
  - Score and winner are updated and visible at n+1, when HOLD starts.
  - HOLD occupies cycles n+1 through n+HOLD_CYCLES.
  - START or OVER follows at n+HOLD_CYCLES+1.
  - If START, PLAY resumes at n+HOLD_CYCLES+2.
- Presses during START, HOLD or OVER are dropped. They are not queued.
- An end light that is on without a matching press does not end the round.

## Test plan
(HOLD_CYCLES = 4, WIN_SCORE = 3)
- Reset high for 2 cycles, then low → round_reset = 1 during Reset and for 1 cycle after; PLAY on the next cycle; all scores 0, match_over = 0.
- In PLAY: L_press alone → L_move = 1 in the same cycle. L_press and R_press together → both outputs 0, state stays PLAY.
- left_end = 1 with L_press at cycle n → L_move = 0, score_L = 1 and winner = 0 at n+1; round_reset = 0 for n+1..n+4; round_reset = 1 at n+5; PLAY at n+6. Presses during n+1..n+5 produce no moves.
- right_end = 1 with L_press and R_press together → no win, no moves, scores unchanged.
- Three right round wins → after the third HOLD, match_over = 1, score_R = 3, winner = 1. Further presses with right_end = 1 change nothing for 20 cycles.
- Reset asserted mid-HOLD with score_L = 2 → next cycle: scores 0, round_reset = 1. After release, a normal START→PLAY sequence.
